// File: rtl/salvo_sequencer.sv
// Round-robin sequencer sharing one capacitor fire channel between NPADS launch pads.
// Define SALVO_DURATION_EN to capture the FIRE-state duration on fire_cycles/fire_cycles_valid.
module salvo_sequencer #(
   parameter int          NPADS         = 4,
   parameter logic [15:0] SETTLE_CYCLES = 16'd480,
   parameter logic [23:0] FIRE_TIMEOUT  = 24'd4_800_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NPADS-1:0] pad_req,
   input  logic             cap_ready,
   input  logic             fire_done,
   input  logic             abort,
   input  logic             clear_fault,
   output logic [NPADS-1:0] pad_sel,
   output logic             fire_go,
   output logic             busy,
   output logic [2:0]       cur_pad,
   output logic [NPADS-1:0] fired,
   output logic             fault,
   output logic [23:0]      fire_cycles,
   output logic             fire_cycles_valid
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_WAIT_CAP = 3'd2,
      ST_FIRE     = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   localparam logic [NPADS-1:0] ONE_PAD     = {{(NPADS-1){1'b0}}, 1'b1};
   localparam logic [NPADS-1:0] NO_PAD      = {NPADS{1'b0}};
   localparam logic [NPADS-1:0] ALL_PADS    = {NPADS{1'b1}};
   localparam logic [23:0]      SETTLE_LAST = {8'd0, SETTLE_CYCLES - 16'd1};
   localparam logic [23:0]      FIRE_LAST   = FIRE_TIMEOUT - 24'd1;

   state_t           state_q, state_d;
   logic [NPADS-1:0] pending_q, pending_d;
   logic [NPADS-1:0] fired_q, fired_d;
   logic [2:0]       rr_q, rr_d;
   logic [2:0]       cur_pad_q, cur_pad_d;
   logic [23:0]      cnt_q, cnt_d;
   logic [NPADS-1:0] pad_sel_q, pad_sel_d;
   logic             fire_go_q, fire_go_d;
   logic             busy_q, busy_d;
   logic             fault_q, fault_d;
   logic [23:0]      fire_cycles_q, fire_cycles_d;
   logic             fire_cycles_valid_q, fire_cycles_valid_d;

   logic [NPADS-1:0] clr_s;
   logic [NPADS-1:0] grant_oh_s;
   logic [3:0]       pick_s;

   // Returns {found, index} of the first pending pad after ptr, wrapping modulo NPADS.
   function automatic logic [3:0] rr_pick(input logic [NPADS-1:0] req, input logic [2:0] ptr);
      logic [3:0]       pick;
      logic [NPADS-1:0] rot;
      int               idx;
      pick = 4'd0;
      for (int i = 1; i <= NPADS; i++) begin
         idx  = int'(ptr) + i;
         idx  = (idx >= NPADS) ? (idx - NPADS) : idx;
         rot  = req >> idx;
         pick = (!pick[3] && rot[0]) ? {1'b1, 3'(idx)} : pick;
      end
      return pick;
   endfunction

   // Next-state, pending/fired bookkeeping and decoded output values.
   always_comb begin
      state_d             = state_q;
      fired_d             = fired_q;
      rr_d                = rr_q;
      cur_pad_d           = cur_pad_q;
      cnt_d               = cnt_q;
      fire_cycles_d       = fire_cycles_q;
      fire_cycles_valid_d = 1'b0;
      clr_s               = NO_PAD;
      grant_oh_s          = ONE_PAD << cur_pad_q;
      pick_s              = rr_pick(pending_q, rr_q);

      case (state_q)
         ST_IDLE: begin
            if (!abort && pick_s[3]) begin
               state_d   = ST_SELECT;
               cur_pad_d = pick_s[2:0];
               rr_d      = pick_s[2:0];
               cnt_d     = 24'd0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (abort) begin
               state_d = ST_RELEASE;
               cnt_d   = 24'd0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_WAIT_CAP;
               cnt_d   = 24'd0;
            end else begin
               cnt_d   = cnt_q + 24'd1;
            end
         end
         ST_WAIT_CAP: begin
            if (abort) begin
               state_d = ST_RELEASE;
               cnt_d   = 24'd0;
            end else if (cap_ready) begin
               state_d = ST_FIRE;
               cnt_d   = 24'd0;
            end else begin
               state_d = ST_WAIT_CAP;
            end
         end
         ST_FIRE: begin
            // A completed fire outranks both abort and the timeout in the same cycle.
            if (fire_done) begin
               state_d = ST_RELEASE;
               cnt_d   = 24'd0;
               fired_d = fired_q | grant_oh_s;
               clr_s   = grant_oh_s;
`ifdef SALVO_DURATION_EN
               fire_cycles_d       = cnt_q + 24'd1;
               fire_cycles_valid_d = 1'b1;
`else
               fire_cycles_d       = 24'd0;
               fire_cycles_valid_d = 1'b0;
`endif
            end else if (abort) begin
               state_d = ST_RELEASE;
               cnt_d   = 24'd0;
            end else if (cnt_q == FIRE_LAST) begin
               state_d = ST_FAULT;
               cnt_d   = 24'd0;
            end else begin
               cnt_d   = cnt_q + 24'd1;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 24'd0;
            end else begin
               cnt_d   = cnt_q + 24'd1;
            end
         end
         ST_FAULT: begin
            if (clear_fault) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 24'd0;
         end
      endcase

      if (abort) begin
         clr_s = ALL_PADS;
      end else begin
         clr_s = clr_s;
      end

      pending_d = (pending_q | (pad_req & ~fired_q)) & ~clr_s;

      // The relay is driven only while a grant is active and never during RELEASE.
      if (state_d == ST_SELECT || state_d == ST_WAIT_CAP || state_d == ST_FIRE) begin
         pad_sel_d = ONE_PAD << cur_pad_d;
      end else begin
         pad_sel_d = NO_PAD;
      end
      fire_go_d = (state_d == ST_FIRE);
      busy_d    = (state_d != ST_IDLE);
      fault_d   = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q             <= ST_IDLE;
         pending_q           <= NO_PAD;
         fired_q             <= NO_PAD;
         rr_q                <= 3'(NPADS - 1);
         cur_pad_q           <= 3'd0;
         cnt_q               <= 24'd0;
         pad_sel_q           <= NO_PAD;
         fire_go_q           <= 1'b0;
         busy_q              <= 1'b0;
         fault_q             <= 1'b0;
         fire_cycles_q       <= 24'd0;
         fire_cycles_valid_q <= 1'b0;
      end else begin
         state_q             <= state_d;
         pending_q           <= pending_d;
         fired_q             <= fired_d;
         rr_q                <= rr_d;
         cur_pad_q           <= cur_pad_d;
         cnt_q               <= cnt_d;
         pad_sel_q           <= pad_sel_d;
         fire_go_q           <= fire_go_d;
         busy_q              <= busy_d;
         fault_q             <= fault_d;
         fire_cycles_q       <= fire_cycles_d;
         fire_cycles_valid_q <= fire_cycles_valid_d;
      end
   end

   assign pad_sel           = pad_sel_q;
   assign fire_go           = fire_go_q;
   assign busy              = busy_q;
   assign cur_pad           = cur_pad_q;
   assign fired             = fired_q;
   assign fault             = fault_q;
   assign fire_cycles       = fire_cycles_q;
   assign fire_cycles_valid = fire_cycles_valid_q;

endmodule

// File: doc/salvo_sequencer.md
Name: salvo_sequencer

Overview:
- Shares the single capacitor fire channel (charger, PWM current loop, discharge path) between NPADS launch pads.
- Latches per-pad fire requests and grants one pad at a time in round-robin order.
- For each grant: closes the pad relay, waits for relay settle, waits for the cap-charged flag, then holds fire_go to the fire controller until fire_done or timeout.
- Sits between the pad-select panel and the existing fire state machine.

Parameters:
- NPADS, 4: number of launch pads; range 2..8.
- SETTLE_CYCLES, 16'd480: relay settle time, in clk cycles, applied on close and on open; minimum 1.
- FIRE_TIMEOUT, 24'd4_800_000: maximum clk cycles fire_go stays high before a fault.

Ports:
- clk  input  1  system clock (48 MHz).
- reset  input  1  synchronous, active-low reset (0 = reset).
- pad_req  input  NPADS  level request per pad; sampled every cycle.
- cap_ready  input  1  charger done flag; capacitor at full voltage.
- fire_done  input  1  one-cycle pulse from the fire controller when a fire sequence ends.
- abort  input  1  level; while high, cancels the current and all pending fires.
- clear_fault  input  1  one-cycle pulse; leaves FAULT.
- pad_sel  output  NPADS  one-hot relay drive for the granted pad; all zero otherwise.
- fire_go  output  1  level; fire controller enable.
- busy  output  1  high in any state other than IDLE.
- cur_pad  output  3  index of the granted pad; holds its last value.
- fired  output  NPADS  sticky per-pad "has fired" status.
- fault  output  1  high in FAULT.
- fire_cycles  output  24  duration of the last completed fire (see Optional Feature).
- fire_cycles_valid  output  1  one-cycle pulse when fire_cycles updates.

Behaviour:
- Reset (reset==0): state=IDLE; pending=0; fired=0; rr_ptr=NPADS-1; cur_pad=0; counters=0. All outputs 0.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Pending register:
  - pending <= (pending | (pad_req & ~fired)) & ~clr.
  - clr = the granted bit when fire_done is accepted; clr = all ones while abort=1.
  - A request for an already-fired pad is ignored until reset.
- Round-robin: search pending starting at rr_ptr+1 with wrap, modulo NPADS. The first set bit wins. rr_ptr <= the winner on grant.
- State IDLE:
  - If abort=0 and pending!=0: grant the winner, load cur_pad, enter SELECT.
  - Latency: pad_req high in cycle t → pending set at t+1 → SELECT entered at t+2.
- State SELECT:
  - pad_sel = onehot(cur_pad).
  - The settle counter counts SETTLE_CYCLES cycles, then the state moves to WAIT_CAP.
- State WAIT_CAP:
  - pad_sel held.
  - When cap_ready=1, enter FIRE. There is no timeout in this state.
- State FIRE:
  - pad_sel held; fire_go=1.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - On fire_done=1: fired[cur_pad] <= 1, clear its pending bit, enter RELEASE.
  - Else, if the counter reaches FIRE_TIMEOUT-1: enter FAULT.
  - fire_done and the timeout in the same cycle: fire_done wins.
- State RELEASE:
  - pad_sel=0; fire_go=0.
  - Count SETTLE_CYCLES cycles, then enter IDLE.
  - No new grant is made until the relay is open.
- State FAULT:
  - pad_sel=0; fire_go=0; fault=1.
  - pending is frozen but still accepts new requests.
  - clear_fault → IDLE. fired[cur_pad] is not set.
- Abort (any state except FAULT and RELEASE):
  - Next state is RELEASE; fire_go drops on the next cycle.
  - All pending bits are cleared.
  - Abort in IDLE only clears pending.
  - fire_done and abort in the same cycle while in FIRE: the fire counts as done (fired set), then RELEASE.
- Reset asserted mid-operation forces the reset values on the next clock edge, including pad_sel=0 and fire_go=0.
- fire_go is never high unless pad_sel is one-hot and was stable for at least SETTLE_CYCLES cycles.

Optional Feature:
- Macro: SALVO_DURATION_EN.
- Defined:
  - A 24-bit counter counts FIRE-state cycles; the count includes the fire_done cycle.
  - On fire_done acceptance, fire_cycles <= count and fire_cycles_valid pulses for 1 cycle.
  - Timeout and abort do not update fire_cycles.
- Not defined: fire_cycles=0 and fire_cycles_valid=0 permanently; the ports remain.

Test Plan (NPADS=4, SETTLE_CYCLES=4, FIRE_TIMEOUT=100):
- Single fire: pad_req=4'b0100 for 1 cycle, cap_ready=1, fire_done pulsed 10 cycles after fire_go rises.
  - Expect pad_sel=4'b0100 for 4+10+… cycles, fire_go high exactly 10 cycles.
  - Expect fired=4'b0100, busy low 4 cycles after fire_done (RELEASE).
- Round-robin: pad_req=4'b1011 held, each fire_done after 5 cycles.
  - Expect grant order pads 0,1,3, then IDLE with fired=4'b1011.
  - Re-asserting pad_req=4'b0001 yields no grant.
- Cap wait: cap_ready=0 after settle.
  - Expect the block to stay in WAIT_CAP with fire_go=0 and pad_sel held for 50 cycles.
  - Raise cap_ready: fire_go rises 1 cycle later.
- Timeout: no fire_done.
  - Expect fire_go high exactly 100 cycles, then fault=1, pad_sel=0, fired unchanged.
  - Pulse clear_fault: IDLE, and the same pad is re-granted.
- Abort mid-fire: abort at FIRE cycle 3 with pad_req=4'b0110.
  - Expect fire_go=0 next cycle, pending=0, RELEASE lasting 4 cycles.
  - fired=0.
- Duration (SALVO_DURATION_EN defined): fire_done on the 7th FIRE cycle → fire_cycles=7, one-cycle valid pulse. With the macro undefined, fire_cycles stays 0.
